// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO plus one-at-a-time issue sequencer in front of a UART transmitter.
//   system side : wr_en_i/wr_data_i in; full_o, empty_o, count_o, overflow_o (dropped write) out
//   tx side     : tx_en_o strobe with tx_data_o out; tx_done_i in; timeout_o when done never came
//   busy_o      : sequencer active or bytes still queued
module uart_tx_buffer #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 60000
) (
    input  logic              clk_i,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [7:0]        wr_data_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_o,
    output logic              tx_en_o,
    output logic [7:0]        tx_data_o,
    input  logic              tx_done_i,
    output logic              timeout_o,
    output logic              busy_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state_q, state_d;
    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [15:0]       wd_q, wd_d;
    logic              tx_en_q, tx_en_d, ovf_q, ovf_d, to_q, to_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              wr_ok, pop;

    assign full_o     = count_q == (ADDR_W+1)'(DEPTH);
    assign empty_o    = count_q == '0;
    assign count_o    = count_q;
    assign overflow_o = ovf_q;
    assign tx_en_o    = tx_en_q;
    assign tx_data_o  = tx_data_q;
    assign timeout_o  = to_q;
    assign busy_o     = (state_q != IDLE) | ~empty_o;

    // full_o comes from the pre-edge count, so a write is refused even when a pop frees a slot on the same edge
    assign wr_ok = wr_en_i & ~full_o;
    assign pop   = (state_q == IDLE) & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = (wr_ok & ~pop) ? count_q + 1'b1 :
                   (pop & ~wr_ok) ? count_q - 1'b1 : count_q;
        ovf_d    = wr_en_i & full_o;
    end

    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        tx_en_d   = 1'b0;
        tx_data_d = tx_data_q;
        wd_d      = wd_q;
        to_d      = 1'b0;
        case (state_q)
            IDLE: if (pop) begin
                state_d   = ISSUE;
                tx_en_d   = 1'b1;
                tx_data_d = mem_q[rd_ptr_q];
                rd_ptr_d  = rd_ptr_q + 1'b1;
            end
            ISSUE: begin
                state_d = WAIT;
                wd_d    = '0;
            end
            WAIT: begin
                // a done pulse on the expiry cycle wins, so no timeout is reported
                if (tx_done_i) state_d = IDLE;
                else if (wd_q == 16'(TIMEOUT_CYC - 1)) begin
                    state_d = IDLE;
                    to_d    = 1'b1;
                end else wd_d = wd_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wd_q      <= '0;
            tx_en_q   <= 1'b0;
            tx_data_q <= 8'h00;
            ovf_q     <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            wd_q      <= wd_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
            ovf_q     <= ovf_d;
            to_q      <= to_d;
        end
    end
endmodule
